npu_result_writeback: RTL
=========================

Name: npu_result_writeback

Overview:
- Downstream stage of the NPU result path.
- Accepts the NPU's result stream: one word per cycle, carrying a byte address and data, qualified by a write-enable.
- Buffers the stream in a small FIFO and drains it into the shared data-memory write port only in cycles the CPU does not own that port.
- Checks each word for alignment and range, counts completed matrices, and pulses `done` once per stored matrix.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte address width
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- MAT_ELEMS, 9, result words per matrix (3x3)
- MEM_BYTES, 1024, data memory size in bytes; addresses ≥ MEM_BYTES are out of range

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  NPU result word valid (NPU pass_we)
- in_addr  in  ADDR_W  result byte address
- in_data  in  DATA_W  result data
- cpu_mem_busy  in  1  CPU drives the data-memory port this cycle; no drain allowed
- clear  in  1  synchronous clear of sticky flags and the element counter
- mem_we  out  1  data-memory write enable
- mem_addr  out  ADDR_W  data-memory byte address
- mem_wdata  out  DATA_W  data-memory write data
- done  out  1  one-cycle pulse when MAT_ELEMS words have been written
- level  out  log2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- addr_err  out  1  sticky: a word was dropped for misalignment or out-of-range address

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; level=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, done=0, overflow=0, addr_err=0.
  - Element counter=0; FSM enters IDLE.
  - Reset mid-drain discards all buffered words; no partial write is issued after reset deasserts.
- Input acceptance, evaluated at each rising edge with in_valid=1:
  - in_addr[1:0]≠0 or in_addr ≥ MEM_BYTES: word dropped, addr_err set.
  - Else FIFO full and no pop this edge: word dropped, overflow set.
  - Else word pushed.
  - When full, a push and a pop at the same edge are both performed; level is unchanged.
- Pop condition at each edge: FIFO not empty, cpu_mem_busy=0, FSM not in DONE.
- Pop outputs:
  - The popped entry is registered onto mem_addr/mem_wdata with mem_we=1 for exactly the following cycle.
  - In cycles without a pop, mem_we=0 and mem_addr/mem_wdata hold their last values.
- Latency: a word presented while the FIFO is empty and cpu_mem_busy=0 appears on mem_we two cycles later (push edge, then pop edge). A word pushed at an edge is never popped at that same edge.
- Throughput: one word per cycle in steady state. cpu_mem_busy=1 stalls draining without losing data until the FIFO is full.
- FSM:
  - IDLE: level=0, counter=0. A push moves to ACTIVE.
  - ACTIVE: each pop increments the counter. The pop that brings it to MAT_ELEMS moves to DONE and resets the counter to 0.
  - DONE: lasts one cycle. done=1, aligned with mem_we of the final element. No pop this cycle. Next state is ACTIVE if level>0, else IDLE.
- Counter width: ceil(log2(MAT_ELEMS+1)). It never wraps past MAT_ELEMS.
- clear=1 at an edge:
  - overflow, addr_err and counter go to 0.
  - FIFO contents and any in-flight mem_we are unaffected.
  - clear has priority over a same-edge counter increment and over a same-edge flag set.
- Sticky flags stay set until clear or rst.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer MSB; level = wr_ptr − rd_ptr.

Test Plan:
- Basic matrix: reset; 9 consecutive in_valid words, addr 0x40..0x60 step 4, data 1..9, cpu_mem_busy=0 -> mem_we high cycles 2..10 after the first word with matching addr/data; done pulses with the 9th write; level returns to 0; FSM returns to IDLE.
- CPU contention: same 9 words with cpu_mem_busy=1 for cycles 0–5 -> no mem_we while busy, level peaks at 6, all 9 writes in order afterwards, one done, overflow=0.
- Overflow: DEPTH=16, cpu_mem_busy=1, 18 words pushed -> level=16, overflow=1, words 17–18 never written; after busy drops, exactly 16 writes occur; clear -> overflow=0.
- Address errors: words at 0x42 and 0x400 (MEM_BYTES=1024) among valid words -> both dropped, addr_err=1, no mem_we with those addresses, counter counts only valid writes.
- Full boundary: FIFO full with cpu_mem_busy=0 and in_valid=1 -> push and pop at the same edge, level stays 16, overflow stays 0.
- Async reset mid-drain: rst asserted with level=5 and mem_we=1 -> outputs 0 immediately (before next edge), level=0, no writes after release.

Source files
------------

// File: rtl/npu_result_writeback.sv
// NPU result writeback: buffers the NPU result stream in a FIFO and drains it
// into the shared data-memory write port whenever the CPU is not using it.
module npu_result_writeback #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAT_ELEMS = 9,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      cpu_mem_busy,
  input  logic                      clear,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(MAT_ELEMS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    level_q, level_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic                addr_err_q, addr_err_d;

  logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [DEPTH];

  logic                empty_c, full_c, addr_ok_c, pop_c, push_c;
  logic [IDX_W-1:0]    wr_idx_c, rd_idx_c;

  // Acceptance and drain decisions; emptiness uses the pre-edge level so a
  // word is never pushed and popped at the same edge.
  always_comb begin
    empty_c   = (level_q == '0);
    full_c    = (level_q == PTR_W'(DEPTH));
    addr_ok_c = (in_addr[1:0] == 2'b00) && (in_addr < ADDR_W'(MEM_BYTES));
    pop_c     = !empty_c && !cpu_mem_busy && (state_q != DONE);
    push_c    = in_valid && addr_ok_c && (!full_c || pop_c);
    wr_idx_c  = wr_ptr_q[IDX_W-1:0];
    rd_idx_c  = rd_ptr_q[IDX_W-1:0];
  end

  // Pointers, occupancy, memory-port outputs and sticky flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    mem_we_d    = pop_c;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    overflow_d  = overflow_q;
    addr_err_d  = addr_err_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      mem_addr_d  = fifo_addr_q[rd_idx_c];
      mem_wdata_d = fifo_data_q[rd_idx_c];
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + PTR_W'(1);
      2'b01:   level_d = level_q - PTR_W'(1);
      default: level_d = level_q;
    endcase

    if (in_valid && !addr_ok_c) begin
      addr_err_d = 1'b1;
    end
    if (in_valid && addr_ok_c && full_c && !pop_c) begin
      overflow_d = 1'b1;
    end
    if (clear) begin
      overflow_d = 1'b0;
      addr_err_d = 1'b0;
    end
  end

  // Matrix-completion FSM and element counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (push_c) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pop_c) begin
          if (cnt_q == CNT_W'(MAT_ELEMS - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        // Uses next-cycle occupancy so a word pushed now is not stranded in IDLE.
        state_d = (level_d != '0) ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_addr_q[wr_idx_c] <= in_addr;
      fifo_data_q[wr_idx_c] <= in_data;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign addr_err  = addr_err_q;

endmodule
